paddle_ctrl: RTL



---
 rtl/paddle_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/paddle_ctrl.sv
// Paddle vertical position sequencer: first-press step, repeat delay, then per-frame repeat.
// Optional macro PADDLE_ACCEL_EN doubles the step after ACCEL_TICKS repeat steps.
module paddle_ctrl #(
  parameter int Y_W          = 10,
  parameter int SCREEN_H     = 480,
  parameter int PADDLE_H     = 64,
  parameter int STEP         = 4,
  parameter int INIT_Y       = 208,
  parameter int REPEAT_DELAY = 8,
  parameter int ACCEL_TICKS  = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           frame_tick,
  input  logic [1:0]     move,
  input  logic           freeze,
  output logic [Y_W-1:0] paddle_y,
  output logic           at_top,
  output logic           at_bottom,
  output logic           moving,
  output logic           step_evt
);

  localparam int MAX_Y = SCREEN_H - PADDLE_H;
  localparam int CNT_W = $clog2(REPEAT_DELAY + 1);
  localparam logic [Y_W:0] MAX_Y_X = (Y_W+1)'(MAX_Y);

  typedef enum logic [1:0] {S_IDLE, S_PRESS, S_DELAY, S_REPEAT} state_t;

  state_t           r_state;
  logic [Y_W-1:0]   r_y;
  logic             r_dir;
  logic [CNT_W-1:0] r_delay_cnt;
  logic             r_step_evt;

  logic [Y_W:0] w_step;
  logic [Y_W:0] w_y_ext;
  logic [Y_W:0] w_up;
  logic [Y_W:0] w_dn_sum;
  logic [Y_W:0] w_dn;
  logic [Y_W:0] w_next_ext;
  logic         w_hold;
  logic         w_step_now;

  // Direction still held and nothing forcing a return to IDLE or a re-press.
  assign w_hold = !freeze && !move[1] && (move[0] == r_dir);

  assign w_step_now = frame_tick && w_hold &&
                      ((r_state == S_PRESS) || (r_state == S_REPEAT) ||
                       ((r_state == S_DELAY) &&
                        (r_delay_cnt == CNT_W'(REPEAT_DELAY - 1))));

`ifdef PADDLE_ACCEL_EN
  localparam int ACC_W = $clog2(ACCEL_TICKS + 1);
  logic [ACC_W-1:0] r_acc_cnt;

  always_ff @(posedge clk) begin
    if (rst || (r_state != S_REPEAT)) begin
      r_acc_cnt <= '0;
    end else if (w_step_now && (r_acc_cnt != ACC_W'(ACCEL_TICKS))) begin
      r_acc_cnt <= r_acc_cnt + 1'b1;
    end
  end

  assign w_step = (r_acc_cnt == ACC_W'(ACCEL_TICKS)) ? (Y_W+1)'(2 * STEP)
                                                     : (Y_W+1)'(STEP);
`else
  assign w_step = (Y_W+1)'(STEP);
`endif

  assign w_y_ext    = {1'b0, r_y};
  assign w_up       = (w_y_ext < w_step) ? '0 : (w_y_ext - w_step);
  assign w_dn_sum   = w_y_ext + w_step;
  assign w_dn       = (w_dn_sum > MAX_Y_X) ? MAX_Y_X : w_dn_sum;
  assign w_next_ext = r_dir ? w_dn : w_up;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_y         <= Y_W'(INIT_Y);
      r_dir       <= 1'b0;
      r_delay_cnt <= '0;
      r_step_evt  <= 1'b0;
    end else begin
      r_step_evt <= 1'b0;
      if (r_state == S_IDLE) begin
        if (!freeze && !move[1]) begin
          r_state <= S_PRESS;
          r_dir   <= move[0];
        end
      end else if (freeze || move[1]) begin
        r_state <= S_IDLE;
      end else if (move[0] != r_dir) begin
        r_state <= S_PRESS;
        r_dir   <= move[0];
      end else if (frame_tick) begin
        case (r_state)
          S_PRESS: begin
            r_delay_cnt <= '0;
            r_state     <= S_DELAY;
          end
          S_DELAY: begin
            if (r_delay_cnt == CNT_W'(REPEAT_DELAY - 1)) r_state <= S_REPEAT;
            else r_delay_cnt <= r_delay_cnt + 1'b1;
          end
          default: ;
        endcase
      end

      // Clamped steps at a limit leave the position alone and raise no event.
      if (w_step_now) begin
        r_y        <= w_next_ext[Y_W-1:0];
        r_step_evt <= (w_next_ext != w_y_ext);
      end
    end
  end

  assign paddle_y  = r_y;
  assign at_top    = (r_y == '0);
  assign at_bottom = (r_y == Y_W'(MAX_Y));
  assign moving    = (r_state != S_IDLE);
  assign step_evt  = r_step_evt;

endmodule
